pulse_train_gen: RTL

Per-channel stimulation waveform sequencer that sits directly upstream of the DAC `spi_controller` channel. It produces the 16-bit DAC code for each DAC update slot from host-programmed amplitude, pulse width, period and pulse count, replacing a static user word. One instance is placed per channel (12 total). `tick` comes from that channel's frame-rate strobe.

---
 rtl/pulse_train_pkg.sv | 18 +
 rtl/pulse_train_phase_counter.sv | 42 ++++
 rtl/pulse_train_gen.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pulse_train_pkg.sv
// pulse_train_pkg: shared state encoding and default widths for the
// pulse_train_gen stimulation sequencer and its phase counter.
package pulse_train_pkg;

   localparam int          PT_CODE_W   = 16;
   localparam int          PT_CNT_W    = 16;
   localparam logic [15:0] PT_BASELINE = 16'h0000;

   // CATH is only ever entered when PULSE_TRAIN_BIPHASIC_EN is defined.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ACT  = 3'd1,
      ST_CATH = 3'd2,
      ST_REST = 3'd3,
      ST_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/pulse_train_phase_counter.sv
// phase_counter: tick-driven down counter that times one waveform phase.
// A load takes priority over a tick in the same cycle, so the tick that
// coincides with a phase entry is not counted toward the new phase.
// term_o flags the tick that ends the phase (tick while count == 1).
module phase_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             term_o
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   // Next count: load, else decrement on tick without wrapping below zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (tick_i && (cnt_q != {CNT_W{1'b0}})) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_o = tick_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: per-channel stimulation waveform sequencer feeding the
// DAC SPI controller. Produces the DAC code per update slot from latched
// amplitude / pulse width / period / pulse count.
// Optional feature: define PULSE_TRAIN_BIPHASIC_EN to add a cathodic phase
// (~amplitude for pulse_width ticks) after every active phase.
module pulse_train_gen
   import pulse_train_pkg::*;
#(
   parameter int                CODE_W   = PT_CODE_W,
   parameter int                CNT_W    = PT_CNT_W,
   parameter logic [CODE_W-1:0] BASELINE = PT_BASELINE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic              start,
   input  logic              stop,
   input  logic [CODE_W-1:0] amplitude,
   input  logic [CNT_W-1:0]  pulse_width,
   input  logic [CNT_W-1:0]  period,
   input  logic [CNT_W-1:0]  num_of_pulses,
   output logic [CODE_W-1:0] dac_code,
   output logic              code_update,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic [CNT_W-1:0]  pulse_count
);

   state_e            state_d, state_q;
   logic [CODE_W-1:0] amp_d, amp_q;
   logic [CNT_W-1:0]  pw_d, pw_q;
   logic [CNT_W-1:0]  per_d, per_q;
   logic [CNT_W-1:0]  num_d, num_q;
   logic [CNT_W-1:0]  pulse_count_d, pulse_count_q;
   logic              cfg_err_d, cfg_err_q;
   logic [CODE_W-1:0] dac_code_d, dac_code_q;
   logic              code_update_d, code_update_q;
   logic              busy_d, busy_q;
   logic              done_d, done_q;

   logic              cfg_ok_s;
   logic [CNT_W-1:0]  rest_len_s;
   logic [CNT_W-1:0]  count_inc_s;
   logic              cnt_load_s;
   logic [CNT_W-1:0]  cnt_val_s;
   logic              term_s;

`ifdef PULSE_TRAIN_BIPHASIC_EN
   // Both phases must fit with at least one rest tick; doubling needs a carry bit.
   assign cfg_ok_s   = (pulse_width != {CNT_W{1'b0}}) &&
                       ({1'b0, period} > {pulse_width, 1'b0});
   assign rest_len_s = per_q - (pw_q << 1);
`else
   assign cfg_ok_s   = (pulse_width != {CNT_W{1'b0}}) && (period > pulse_width);
   assign rest_len_s = per_q - pw_q;
`endif

   // Completed-pulse count saturates so a continuous train never wraps.
   assign count_inc_s = (pulse_count_q == {CNT_W{1'b1}}) ? pulse_count_q
                                                         : pulse_count_q + CNT_W'(1);

   phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_i     (tick),
      .load_i     (cnt_load_s),
      .load_val_i (cnt_val_s),
      .term_o     (term_s)
   );

   // Sequencer next state, shadow config capture and next output values.
   always_comb begin
      state_d       = state_q;
      amp_d         = amp_q;
      pw_d          = pw_q;
      per_d         = per_q;
      num_d         = num_q;
      pulse_count_d = pulse_count_q;
      cfg_err_d     = cfg_err_q;
      dac_code_d    = dac_code_q;
      cnt_load_s    = 1'b0;
      cnt_val_s     = pw_q;

      if (stop && (state_q != ST_IDLE)) begin
         // Abort: no completion, count holds.
         state_d    = ST_IDLE;
         dac_code_d = BASELINE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               dac_code_d = BASELINE;
               if (start && !stop) begin
                  if (cfg_ok_s) begin
                     amp_d         = amplitude;
                     pw_d          = pulse_width;
                     per_d         = period;
                     num_d         = num_of_pulses;
                     pulse_count_d = {CNT_W{1'b0}};
                     cfg_err_d     = 1'b0;
                     cnt_load_s    = 1'b1;
                     cnt_val_s     = pulse_width;
                     dac_code_d    = amplitude;
                     state_d       = ST_ACT;
                  end else begin
                     cfg_err_d = 1'b1;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ACT: begin
               dac_code_d = amp_q;
               if (term_s) begin
`ifdef PULSE_TRAIN_BIPHASIC_EN
                  state_d    = ST_CATH;
                  cnt_load_s = 1'b1;
                  cnt_val_s  = pw_q;
                  dac_code_d = ~amp_q;
`else
                  state_d    = ST_REST;
                  cnt_load_s = 1'b1;
                  cnt_val_s  = rest_len_s;
                  dac_code_d = BASELINE;
`endif
               end else begin
                  state_d = ST_ACT;
               end
            end
`ifdef PULSE_TRAIN_BIPHASIC_EN
            ST_CATH: begin
               // Mirror about midscale for offset-binary DAC codes.
               dac_code_d = ~amp_q;
               if (term_s) begin
                  state_d    = ST_REST;
                  cnt_load_s = 1'b1;
                  cnt_val_s  = rest_len_s;
                  dac_code_d = BASELINE;
               end else begin
                  state_d = ST_CATH;
               end
            end
`endif
            ST_REST: begin
               dac_code_d = BASELINE;
               if (term_s) begin
                  pulse_count_d = count_inc_s;
                  if ((num_q != {CNT_W{1'b0}}) && (count_inc_s == num_q)) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d    = ST_ACT;
                     cnt_load_s = 1'b1;
                     cnt_val_s  = pw_q;
                     dac_code_d = amp_q;
                  end
               end else begin
                  state_d = ST_REST;
               end
            end
            ST_DONE: begin
               state_d    = ST_IDLE;
               dac_code_d = BASELINE;
            end
            default: begin
               state_d    = ST_IDLE;
               dac_code_d = BASELINE;
            end
         endcase
      end

      // Update strobe on any code change, and always on ACT entry even if
      // the amplitude happens to equal the code already on the bus.
      code_update_d = (dac_code_d != dac_code_q) ||
                      ((state_d == ST_ACT) && (state_q != ST_ACT));
      busy_d        = (state_d != ST_IDLE);
      done_d        = (state_d == ST_DONE);
   end

   // State, shadow configuration and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         amp_q         <= {CODE_W{1'b0}};
         pw_q          <= {CNT_W{1'b0}};
         per_q         <= {CNT_W{1'b0}};
         num_q         <= {CNT_W{1'b0}};
         pulse_count_q <= {CNT_W{1'b0}};
         cfg_err_q     <= 1'b0;
         dac_code_q    <= BASELINE;
         code_update_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         amp_q         <= amp_d;
         pw_q          <= pw_d;
         per_q         <= per_d;
         num_q         <= num_d;
         pulse_count_q <= pulse_count_d;
         cfg_err_q     <= cfg_err_d;
         dac_code_q    <= dac_code_d;
         code_update_q <= code_update_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign dac_code    = dac_code_q;
   assign code_update = code_update_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign cfg_err     = cfg_err_q;
   assign pulse_count = pulse_count_q;

endmodule
